// File: rtl/risc_controller.sv
// risc_controller: eight-phase instruction sequencer for the VeriRISC core.
// A 3-bit phase register steps 0..7 once per instruction. Control strobes
// are decoded combinationally from the registered phase, the IR opcode and
// the ALU zero flag.
//
// Build option: define RISC_CTRL_HALT_LATCH_EN to make HLT latch a halted
// state (phase frozen at 4, halt held high, PC frozen until rst). Without it,
// halt is a one-cycle pulse in phase 4 and HLT behaves as a no-op.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   opcode  in   [2:0] current instruction opcode from the IR
//   zero    in   accumulator-zero flag from the ALU
//   sel     out  address mux select (1 = PC, 0 = IR operand)
//   rd      out  memory read
//   ld_ir   out  load instruction register
//   halt    out  processor halted
//   inc_pc  out  PC increment (counter en)
//   ld_pc   out  PC load (counter load, has priority over inc_pc)
//   ld_ac   out  load accumulator
//   wr      out  memory write
//   data_e  out  drive accumulator onto the data bus
//   phase   out  [2:0] current phase for debug/trace
module risc_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       halt,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic [2:0] phase
);

   localparam int unsigned PHASE_W = 3;
   localparam int unsigned OP_W    = 3;

   localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
   localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
   localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

   typedef enum logic [PHASE_W-1:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   phase_e phase_q, phase_d;
   logic   aluop;

`ifdef RISC_CTRL_HALT_LATCH_EN
   logic halted_q, halted_d;
`endif

   // Phase (and halted flag) register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
`ifdef RISC_CTRL_HALT_LATCH_EN
         halted_q <= 1'b0;
`endif
      end else begin
         phase_q  <= phase_d;
`ifdef RISC_CTRL_HALT_LATCH_EN
         halted_q <= halted_d;
`endif
      end
   end

   // Next phase and control decode.
   always_comb begin
      phase_d = phase_e'(PHASE_W'(phase_q) + PHASE_W'(1));
      sel     = 1'b0;
      rd      = 1'b0;
      ld_ir   = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      ld_pc   = 1'b0;
      ld_ac   = 1'b0;
      wr      = 1'b0;
      data_e  = 1'b0;
`ifdef RISC_CTRL_HALT_LATCH_EN
      halted_d = halted_q;
`endif
      aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
              (opcode == OP_XOR) || (opcode == OP_LDA);

      case (phase_q)
         PH_INST_ADDR: begin
            sel = 1'b1;
         end
         PH_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         PH_OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (opcode == OP_HLT);
`ifdef RISC_CTRL_HALT_LATCH_EN
            // PC still increments this cycle; the freeze starts next edge.
            if (opcode == OP_HLT) begin
               phase_d  = PH_OP_ADDR;
               halted_d = 1'b1;
            end
`endif
         end
         PH_OP_FETCH: begin
            rd = aluop;
         end
         PH_ALU_OP: begin
            rd     = aluop;
            inc_pc = (opcode == OP_SKZ) && zero;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
         end
         PH_STORE: begin
            rd     = aluop;
            ld_ac  = aluop;
            inc_pc = (opcode == OP_JMP);
            ld_pc  = (opcode == OP_JMP);
            wr     = (opcode == OP_STO);
            data_e = (opcode == OP_STO);
         end
         default: begin
         end
      endcase

`ifdef RISC_CTRL_HALT_LATCH_EN
      // Halted: hold phase 4, only halt asserted, until rst.
      if (halted_q) begin
         phase_d = PH_OP_ADDR;
         sel     = 1'b0;
         rd      = 1'b0;
         ld_ir   = 1'b0;
         halt    = 1'b1;
         inc_pc  = 1'b0;
         ld_pc   = 1'b0;
         ld_ac   = 1'b0;
         wr      = 1'b0;
         data_e  = 1'b0;
      end
`endif
   end

   assign phase = PHASE_W'(phase_q);

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller. Each cycle the expected output
// vector {phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e} is
// pushed to a scoreboard when inputs are driven, then popped and compared
// mid-cycle against the DUT.
module tb_risc_controller;

   logic       clk;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
   logic [2:0] phase;

`ifdef RISC_CTRL_HALT_LATCH_EN
   localparam bit HALT_LATCH = 1'b1;
`else
   localparam bit HALT_LATCH = 1'b0;
`endif

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic [11:0] sb_q[$];
   logic [11:0] exp_v;
   logic [11:0] act_v;
   logic [2:0]  ph_m;
   logic        halted_m;

   risc_controller dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .halt   (halt),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .phase  (phase)
   );

   always #5 clk = ~clk;

   // Expected strobes, written as per-output phase sets.
   function automatic logic [11:0] model_out(input logic [2:0] ph, input logic [2:0] op,
                                             input logic z, input logic hl);
      logic is_alu, e_sel, e_rd, e_ldir, e_halt, e_inc, e_ldpc, e_ldac, e_wr, e_de;
      if (hl) return {3'd4, 4'b0001, 5'b00000};
      is_alu = (op inside {3'd2, 3'd3, 3'd4, 3'd5});
      e_sel  = (ph inside {3'd0, 3'd1, 3'd2, 3'd3});
      e_rd   = (ph inside {3'd1, 3'd2, 3'd3}) || ((ph inside {3'd5, 3'd6, 3'd7}) && is_alu);
      e_ldir = (ph inside {3'd2, 3'd3});
      e_halt = (ph == 3'd4) && (op == 3'd0);
      e_inc  = (ph == 3'd4) || ((ph == 3'd6) && (op == 3'd1) && z) ||
               ((ph == 3'd7) && (op == 3'd7));
      e_ldpc = (ph inside {3'd6, 3'd7}) && (op == 3'd7);
      e_ldac = (ph == 3'd7) && is_alu;
      e_wr   = (ph == 3'd7) && (op == 3'd6);
      e_de   = (ph inside {3'd6, 3'd7}) && (op == 3'd6);
      return {ph, e_sel, e_rd, e_ldir, e_halt, e_inc, e_ldpc, e_ldac, e_wr, e_de};
   endfunction

   // Drive inputs for this cycle, push expectation, advance phase model.
   task automatic drive(input logic [2:0] op, input logic z);
      opcode = op;
      zero   = z;
      sb_q.push_back(model_out(ph_m, op, z, halted_m));
      if (halted_m) ph_m = 3'd4;
      else if (HALT_LATCH && (ph_m == 3'd4) && (op == 3'd0)) halted_m = 1'b1;
      else ph_m = ph_m + 3'd1;
   endtask

   function automatic logic [11:0] dut_vec();
      return {phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e};
   endfunction

   task automatic test_reset();
      sb_q.push_back(model_out(3'd0, 3'd0, 1'b0, 1'b0));
      #1;
      exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
      if (act_v !== exp_v) $display("FAIL reset: got %b want %b", act_v, exp_v);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0; ph_m = 3'd0; halted_m = 1'b0;
   endtask

   task automatic test_add();
      for (int i = 0; i < 8; i++) begin
         drive(3'd2, 1'b0); #2;
         exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
         if (act_v !== exp_v) $display("FAIL add cyc%0d: got %b want %b", i, act_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_ops();
      logic [2:0] ops[3] = '{3'd3, 3'd4, 3'd5};
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 8; i++) begin
            drive(ops[k], 1'($urandom_range(0, 1))); #2;
            exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
            if (act_v !== exp_v)
               $display("FAIL alu op%0d cyc%0d: got %b want %b", ops[k], i, act_v, exp_v);
            else n_pass++;
            @(posedge clk); #1;
         end
   endtask

   task automatic test_skz();
      int incs;
      for (int z = 1; z >= 0; z--) begin
         incs = 0;
         for (int i = 0; i < 8; i++) begin
            drive(3'd1, 1'(z)); #2;
            exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
            if (act_v !== exp_v) $display("FAIL skz z%0d cyc%0d: got %b want %b", z, i, act_v, exp_v);
            else n_pass++;
            incs += int'(inc_pc);
            @(posedge clk); #1;
         end
         n_total++;
         if (incs !== z + 1) $display("FAIL skz_pc_adv z%0d: got %0d want %0d", z, incs, z + 1);
         else n_pass++;
      end
   endtask

   task automatic test_jmp();
      for (int i = 0; i < 8; i++) begin
         drive(3'd7, 1'b1); #2;
         exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
         if (act_v !== exp_v) $display("FAIL jmp cyc%0d: got %b want %b", i, act_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sto();
      for (int i = 0; i < 8; i++) begin
         drive(3'd6, 1'b0); #2;
         exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
         if (act_v !== exp_v) $display("FAIL sto cyc%0d: got %b want %b", i, act_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] op;
      for (int n = 0; n < 6; n++) begin
         op = 3'($urandom_range(1, 7));
         for (int i = 0; i < 8; i++) begin
            drive(op, 1'($urandom_range(0, 1))); #2;
            exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
            if (act_v !== exp_v)
               $display("FAIL b2b ins%0d op%0d cyc%0d: got %b want %b", n, op, i, act_v, exp_v);
            else n_pass++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) begin
         drive(3'd2, 1'b0); #2;
         exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
         if (act_v !== exp_v) $display("FAIL rstmid pre cyc%0d: got %b want %b", i, act_v, exp_v);
         else n_pass++;
         if (i < 5) begin @(posedge clk); #1; end
      end
      // Now mid-phase 5: async reset must act without a clock edge.
      rst = 1'b1; ph_m = 3'd0; halted_m = 1'b0;
      sb_q.push_back(model_out(3'd0, 3'd2, 1'b0, 1'b0));
      #1;
      exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
      if (act_v !== exp_v) $display("FAIL rstmid async: got %b want %b", act_v, exp_v);
      else n_pass++;
      #1; rst = 1'b0;
      drive(3'd2, 1'b0); #1;
      exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
      if (act_v !== exp_v) $display("FAIL rstmid released: got %b want %b", act_v, exp_v);
      else n_pass++;
      @(posedge clk); #1;
      for (int i = 1; i < 8; i++) begin
         drive(3'd2, 1'b0); #2;
         exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
         if (act_v !== exp_v) $display("FAIL rstmid post ph%0d: got %b want %b", i, act_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_hlt();
      // 30 cycles: halted build sits in phase 4; pulse build runs ~4 instructions.
      for (int i = 0; i < 30; i++) begin
         drive(3'd0, 1'b0); #2;
         exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
         if (act_v !== exp_v) $display("FAIL hlt cyc%0d: got %b want %b", i, act_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
      rst = 1'b1; ph_m = 3'd0; halted_m = 1'b0;
      sb_q.push_back(model_out(3'd0, 3'd0, 1'b0, 1'b0));
      #1;
      exp_v = sb_q.pop_front(); act_v = dut_vec(); n_total++;
      if (act_v !== exp_v) $display("FAIL hlt reset: got %b want %b", act_v, exp_v);
      else n_pass++;
      #1; rst = 1'b0;
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; opcode = 3'd0; zero = 1'b0;
      ph_m = 3'd0; halted_m = 1'b0;
      #12;
      test_reset();
      test_add();
      test_alu_ops();
      test_skz();
      test_jmp();
      test_sto();
      test_back_to_back();
      test_reset_mid();
      test_hlt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
